// File: rtl/bpu_pkg.sv
// Shared branch-predictor definitions: default geometry, FSM states and
// the counter/index helpers used by the gshare predictor.
package bpu_pkg;

  localparam int IDX_W_DEF = 9;
  localparam int GHR_W_DEF = 9;
  localparam int CNT_W_DEF = 2;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  // Saturating counter helpers on a 32-bit carrier; callers truncate to CNT_W.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] top;
    top = (32'd1 << w) - 32'd1;
    return (v >= top) ? top : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

  // PC field and history are zero-extended by the caller, so a short GHR
  // only folds into the low index bits.
  function automatic logic [31:0] gshare_idx(input logic [31:0] pc_bits,
                                             input logic [31:0] ghr);
    return pc_bits ^ ghr;
  endfunction

endpackage

// File: rtl/ugshare_tbl.sv
// 1R1W counter array with registered read; a write to the address being
// read in the same cycle is forwarded to the read register.
module ugshare_tbl
  import bpu_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [CNT_W-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [CNT_W-1:0] rdata
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [CNT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/ugshare_pred.sv
// Gshare direction predictor: PC^GHR indexed counter table, speculative
// global history with mispredict repair, and post-reset table sweep.
module ugshare_pred
  import bpu_pkg::*;
#(
  parameter int MXLEN  = 32,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int GHR_W  = GHR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PC_LSB = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pc_valid,
  input  logic [MXLEN-1:0] i_pc,
  output logic             o_ready,
  output logic             o_pred_valid,
  output logic             o_pred_taken,
  output logic [CNT_W-1:0] o_pred_cnt,
  output logic [GHR_W-1:0] o_pred_ghr,
  input  logic             i_pred_br,
  input  logic             i_upd_valid,
  input  logic [MXLEN-1:0] i_upd_pc,
  input  logic [GHR_W-1:0] i_upd_ghr,
  input  logic [CNT_W-1:0] i_upd_cnt,
  input  logic             i_upd_taken,
  input  logic             i_upd_mispred,
  output logic [GHR_W-1:0] o_ghr
);

  localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] init_ptr, init_ptr_nxt;
  logic             tbl_init;
  logic [GHR_W-1:0] ghr, ghr_nxt;

  logic             lkp_p0, upd_p0;
  logic [IDX_W-1:0] lkp_idx_p0, upd_idx_p0;
  logic [CNT_W-1:0] upd_cnt_p0;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;
  logic [CNT_W-1:0] tbl_wdata;

  logic             vld_p1;
  logic [GHR_W-1:0] pred_ghr_p1;
  logic [CNT_W-1:0] cnt_p1;

  // Only the indexed PC slice participates in the hash.
  logic unused_pc;
  assign unused_pc = ^{i_pc, i_upd_pc};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_nxt;
      init_ptr <= init_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_ptr_nxt = init_ptr;
    o_ready      = 1'b0;
    tbl_init     = 1'b0;
    case (state)
      INIT: begin
        tbl_init     = 1'b1;
        init_ptr_nxt = init_ptr + 1'b1;
        if (init_ptr == '1) state_nxt = RUN;
      end
      RUN:     o_ready = 1'b1;
      default: state_nxt = INIT;
    endcase
  end

  // Stage p0: hash lookup and update, form table write
  assign lkp_p0     = i_pc_valid && o_ready;
  assign upd_p0     = i_upd_valid && o_ready;
  assign lkp_idx_p0 = IDX_W'(gshare_idx(32'(i_pc[PC_LSB +: IDX_W]), 32'(ghr)));
  assign upd_idx_p0 = IDX_W'(gshare_idx(32'(i_upd_pc[PC_LSB +: IDX_W]), 32'(i_upd_ghr)));
  assign upd_cnt_p0 = i_upd_taken ? CNT_W'(sat_inc(32'(i_upd_cnt), CNT_W))
                                  : CNT_W'(sat_dec(32'(i_upd_cnt)));

  assign tbl_we    = (tbl_init || upd_p0) && !i_rst;
  assign tbl_waddr = tbl_init ? init_ptr : upd_idx_p0;
  assign tbl_wdata = tbl_init ? WEAK_NT : upd_cnt_p0;

  ugshare_tbl #(
    .IDX_W(IDX_W),
    .CNT_W(CNT_W)
  ) u_tbl (
    .clk  (i_clk),
    .rst  (i_rst),
    .we   (tbl_we),
    .waddr(tbl_waddr),
    .wdata(tbl_wdata),
    .re   (lkp_p0),
    .raddr(lkp_idx_p0),
    .rdata(cnt_p1)
  );

  // Stage p1: prediction outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1      <= 1'b0;
      pred_ghr_p1 <= '0;
    end else begin
      vld_p1 <= lkp_p0;
      if (lkp_p0) pred_ghr_p1 <= ghr;
    end
  end

  assign o_pred_valid = vld_p1;
  assign o_pred_cnt   = cnt_p1;
  assign o_pred_taken = cnt_p1[CNT_W-1];
  assign o_pred_ghr   = pred_ghr_p1;

  // Repair beats the speculative shift; truncating the concatenation keeps
  // the youngest GHR_W bits, which also covers a single-bit history.
  always_comb begin
    ghr_nxt = ghr;
    if (upd_p0 && i_upd_mispred) begin
      ghr_nxt = GHR_W'({i_upd_ghr, i_upd_taken});
    end else if (vld_p1 && i_pred_br) begin
      ghr_nxt = GHR_W'({ghr, o_pred_taken});
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) ghr <= '0;
    else       ghr <= ghr_nxt;
  end

  assign o_ghr = ghr;

endmodule

// File: tb/tb_ugshare_pred.sv
// Directed-vector bench for ugshare_pred with hand-computed expectations
// for the default 512-entry, 9-bit history, 2-bit counter configuration.
module tb_ugshare_pred;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic [31:0] pc;
  logic        ready;
  logic        pred_valid;
  logic        pred_taken;
  logic [1:0]  pred_cnt;
  logic [8:0]  pred_ghr;
  logic        pred_br;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [8:0]  upd_ghr;
  logic [1:0]  upd_cnt;
  logic        upd_taken;
  logic        upd_mispred;
  logic [8:0]  ghr;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] v_pc  [4];
  logic [1:0]  v_cnt [4];
  logic        v_tk  [4];
  logic [1:0]  v_exp [4];
  logic [31:0] r_pc  [6];

  always #5 clk = ~clk;

  ugshare_pred dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pc_valid   (pc_valid),
    .i_pc         (pc),
    .o_ready      (ready),
    .o_pred_valid (pred_valid),
    .o_pred_taken (pred_taken),
    .o_pred_cnt   (pred_cnt),
    .o_pred_ghr   (pred_ghr),
    .i_pred_br    (pred_br),
    .i_upd_valid  (upd_valid),
    .i_upd_pc     (upd_pc),
    .i_upd_ghr    (upd_ghr),
    .i_upd_cnt    (upd_cnt),
    .i_upd_taken  (upd_taken),
    .i_upd_mispred(upd_mispred),
    .o_ghr        (ghr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_valid    = 1'b0;
    pc          = '0;
    pred_br     = 1'b0;
    upd_valid   = 1'b0;
    upd_pc      = '0;
    upd_ghr     = '0;
    upd_cnt     = '0;
    upd_taken   = 1'b0;
    upd_mispred = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] addr);
    pc_valid = 1'b1;
    pc       = addr;
    tick();
    pc_valid = 1'b0;
  endtask

  task automatic update(input logic [31:0] addr, input logic [8:0] h,
                        input logic [1:0] c, input logic tk);
    upd_valid = 1'b1;
    upd_pc    = addr;
    upd_ghr   = h;
    upd_cnt   = c;
    upd_taken = tk;
    tick();
    upd_valid = 1'b0;
  endtask

  // Counts cycles until o_ready while hammering lookups and repairs.
  task automatic wait_ready(input string tag);
    int  n;
    bit  saw;
    n   = 0;
    saw = 1'b0;
    pc_valid    = 1'b1;
    pc          = 32'h100;
    pred_br     = 1'b1;
    upd_valid   = 1'b1;
    upd_mispred = 1'b1;
    upd_ghr     = 9'h1FF;
    upd_taken   = 1'b1;
    while (!ready && n < 600) begin
      tick();
      n++;
      if (pred_valid) saw = 1'b1;
    end
    idle();
    chk({tag, "_cycles"}, n, 512);
    chk({tag, "_no_pred_valid"}, 32'(saw), 0);
    chk({tag, "_ghr_held"}, 32'(ghr), 0);
  endtask

  initial begin
    v_pc[0] = 32'h200; v_cnt[0] = 2'b11; v_tk[0] = 1'b1; v_exp[0] = 2'b11;
    v_pc[1] = 32'h204; v_cnt[1] = 2'b00; v_tk[1] = 1'b0; v_exp[1] = 2'b00;
    v_pc[2] = 32'h208; v_cnt[2] = 2'b10; v_tk[2] = 1'b0; v_exp[2] = 2'b01;
    v_pc[3] = 32'h20C; v_cnt[3] = 2'b01; v_tk[3] = 1'b1; v_exp[3] = 2'b10;
    r_pc[0] = 32'h100; r_pc[1] = 32'h104; r_pc[2] = 32'h200;
    r_pc[3] = 32'h204; r_pc[4] = 32'h208; r_pc[5] = 32'h20C;

    idle();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_pred_valid", 32'(pred_valid), 0);
    chk("rst_pred_taken", 32'(pred_taken), 0);
    chk("rst_pred_cnt", 32'(pred_cnt), 0);
    chk("rst_pred_ghr", 32'(pred_ghr), 0);
    chk("rst_ghr", 32'(ghr), 0);

    rst = 1'b0;
    wait_ready("init");

    lookup(32'h100);
    chk("first_valid", 32'(pred_valid), 1);
    chk("first_cnt", 32'(pred_cnt), 32'h1);
    chk("first_taken", 32'(pred_taken), 0);
    chk("first_pred_ghr", 32'(pred_ghr), 0);
    pred_br = 1'b1;
    tick();
    pred_br = 1'b0;
    chk("shift_nt_ghr", 32'(ghr), 32'h000);
    chk("shift_nt_valid_drop", 32'(pred_valid), 0);

    update(32'h100, 9'h000, 2'b10, 1'b1);
    lookup(32'h100);
    chk("strong_t_cnt", 32'(pred_cnt), 32'h3);
    chk("strong_t_taken", 32'(pred_taken), 1);
    pred_br = 1'b1;
    tick();
    pred_br = 1'b0;
    chk("shift_t_ghr", 32'(ghr), 32'h001);

    // History is now 1, so update with ghr=1 and look up the same PC.
    for (int i = 0; i < 4; i++) begin
      update(v_pc[i], 9'h001, v_cnt[i], v_tk[i]);
      lookup(v_pc[i]);
      chk($sformatf("sat_cnt%0d", i), 32'(pred_cnt), 32'(v_exp[i]));
      chk($sformatf("sat_taken%0d", i), 32'(pred_taken), 32'(v_exp[i][1]));
    end
    chk("correct_upd_ghr_kept", 32'(ghr), 32'h001);

    // pc 0x104 with ghr=1 and pc 0x100 with ghr=0 both hash to idx 0x40.
    upd_valid = 1'b1; upd_pc = 32'h100; upd_ghr = 9'h000;
    upd_cnt   = 2'b01; upd_taken = 1'b1;
    pc_valid  = 1'b1; pc = 32'h104;
    tick();
    idle();
    chk("bypass_cnt", 32'(pred_cnt), 32'h2);
    chk("bypass_taken", 32'(pred_taken), 1);
    chk("bypass_pred_ghr", 32'(pred_ghr), 32'h001);

    lookup(32'h104);
    chk("stored_cnt", 32'(pred_cnt), 32'h2);

    pred_br     = 1'b1;
    pc_valid    = 1'b1; pc = 32'h104;
    upd_valid   = 1'b1; upd_mispred = 1'b1; upd_ghr = 9'h0AA;
    upd_taken   = 1'b1; upd_pc = 32'h300; upd_cnt = 2'b01;
    tick();
    idle();
    chk("repair_ghr", 32'(ghr), 32'h155);
    chk("repair_cycle_pred_ghr", 32'(pred_ghr), 32'h001);
    chk("repair_cycle_cnt", 32'(pred_cnt), 32'h2);

    rst = 1'b1;
    pc_valid = 1'b1; pc = 32'h100;
    tick();
    chk("midrun_rst_ready", 32'(ready), 0);
    chk("midrun_rst_valid", 32'(pred_valid), 0);
    rst = 1'b0;
    wait_ready("reinit");

    for (int i = 0; i < 6; i++) begin
      lookup(r_pc[i]);
      chk($sformatf("reinit_cnt%0d", i), 32'(pred_cnt), 32'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
